// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: detects ecall/ebreak/mret and interrupts, sequences the trap CSR
// writes, then redirects the pipeline. Define CLINT_ASYNC_INT_EN to enable interrupt detection.
module clint_ctrl #(
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [7:0]  int_flag_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        clint_wr_en_o,
    output logic [31:0] clint_wr_addr_o,
    output logic [31:0] clint_wr_data_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] INST_MRET    = 32'h3020_0073;
    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MSTATUS,
        W_MCAUSE,
        W_MRET,
        JUMP
    } state_t;

    state_t      state;
    logic [31:0] cause;
    logic [31:0] ret_pc;
    logic        mret_pending;
    logic        blank;

    logic        inst_ecall;
    logic        inst_ebreak;
    logic        inst_mret;
    logic        sync_trap;
    logic        async_evt;
    logic [31:0] async_cause;
    logic [31:0] async_pc;
    logic        armed;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        unused_sink;

    // Entering a trap: save MIE into MPIE and disable interrupts.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
    endfunction

    // Leaving a trap: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
    endfunction

`ifdef CLINT_ASYNC_INT_EN
    assign async_evt   = (int_flag_i != 8'h00) && csr_mstatus_i[3];
    assign async_cause = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
    assign async_pc    = jump_flag_i ? jump_addr_i : inst_addr_i;
    assign unused_sink = ^MTVEC_ADDR;
`else
    assign async_evt   = 1'b0;
    assign async_cause = CAUSE_EXT;
    assign async_pc    = inst_addr_i;
    assign unused_sink = ^{MTVEC_ADDR, int_flag_i, jump_flag_i, jump_addr_i};
`endif

    assign inst_ecall  = (inst_i == INST_ECALL);
    assign inst_ebreak = (inst_i == INST_EBREAK);
    assign inst_mret   = (inst_i == INST_MRET);
    assign sync_trap   = inst_ecall || inst_ebreak;

    // The IDLE cycle right after JUMP still shows the redirected-away instruction, so it is not armed.
    assign armed     = (state == IDLE) && !blank && !rst;
    assign take_trap = armed && (sync_trap || (!inst_mret && async_evt));
    assign take_mret = armed && !sync_trap && inst_mret;

    assign trap_cause = inst_ecall ? CAUSE_ECALL : (inst_ebreak ? CAUSE_EBREAK : async_cause);
    assign trap_pc    = sync_trap ? inst_addr_i : async_pc;

    assign hold_flag_o = (state != IDLE) || take_trap || take_mret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cause        <= '0;
            ret_pc       <= '0;
            mret_pending <= 1'b0;
            blank        <= 1'b0;
        end else begin
            blank <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_trap) begin
                        cause        <= trap_cause;
                        ret_pc       <= trap_pc;
                        mret_pending <= 1'b0;
                        state        <= W_MEPC;
                    end else if (take_mret) begin
                        mret_pending <= 1'b1;
                        state        <= W_MRET;
                    end
                end
                W_MEPC:    state <= W_MSTATUS;
                W_MSTATUS: state <= W_MCAUSE;
                W_MCAUSE:  state <= JUMP;
                W_MRET:    state <= JUMP;
                JUMP: begin
                    state <= IDLE;
                    blank <= 1'b1;
                end
                default:   state <= IDLE;
            endcase
        end
    end

    // Outputs decode state, latches and CSR values only; inst_i never reaches them.
    always_comb begin
        clint_wr_en_o   = 1'b0;
        clint_wr_addr_o = '0;
        clint_wr_data_o = '0;
        int_assert_o    = 1'b0;
        int_addr_o      = '0;
        case (state)
            W_MEPC: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'h0, MEPC_ADDR};
                clint_wr_data_o = ret_pc;
            end
            W_MSTATUS: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'h0, MSTATUS_ADDR};
                clint_wr_data_o = trap_mstatus(csr_mstatus_i);
            end
            W_MCAUSE: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'h0, MCAUSE_ADDR};
                clint_wr_data_o = cause;
            end
            W_MRET: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'h0, MSTATUS_ADDR};
                clint_wr_data_o = mret_mstatus(csr_mstatus_i);
            end
            JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = mret_pending ? csr_mepc_i : csr_mtvec_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// Bench for clint_ctrl: directed vector table, reset and priority sequences, and random stimulus
// against a queue-based model of the expected CSR write/redirect stream.
module tb_clint_ctrl;
`ifdef CLINT_ASYNC_INT_EN
    localparam bit ASYNC = 1'b1;
`else
    localparam bit ASYNC = 1'b0;
`endif
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] MRET      = 32'h3020_0073;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] A_MEPC    = 32'h341;
    localparam logic [31:0] A_MSTATUS = 32'h300;
    localparam logic [31:0] A_MCAUSE  = 32'h342;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, pc, ja, mtvec, mepc, mstatus;
    logic        jf;
    logic [7:0]  irq;
    logic        wr_en, hold, int_assert;
    logic [31:0] wr_addr, wr_data, int_addr;

    always #5 clk = ~clk;

    clint_ctrl dut (
        .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(pc),
        .jump_flag_i(jf), .jump_addr_i(ja), .int_flag_i(irq),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
        .clint_wr_en_o(wr_en), .clint_wr_addr_o(wr_addr), .clint_wr_data_o(wr_data),
        .hold_flag_o(hold), .int_assert_o(int_assert), .int_addr_o(int_addr)
    );

    typedef struct {
        logic        hold;
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        as;
        logic [31:0] ta;
    } obs_t;

    typedef struct {
        logic [31:0] inst, pc;
        logic        jf;
        logic [31:0] ja;
        logic [7:0]  irq;
        logic [31:0] ms, tvec, epc;
        int          kind;  // 0 nothing, 1 trap, 2 mret
        logic [31:0] e_mepc, e_ms, e_cause, e_tgt;
    } vec_t;

    obs_t        q[$];
    bit          m_blank = 1'b0;
    bit          pend = 1'b0;
    obs_t        pend_w;
    logic [31:0] dut_mcause;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample at negedge, compare with the model, commit the model's CSR write after the edge.
    task automatic cycle(output obs_t o);
        obs_t        e;
        bit          trap, ret;
        logic [31:0] cause, rpc, ms;
        @(negedge clk);
        o.hold = hold; o.en = wr_en; o.addr = wr_addr; o.data = wr_data;
        o.as = int_assert; o.ta = int_addr;
        e = '{hold: 1'b0, en: 1'b0, addr: 32'h0, data: 32'h0, as: 1'b0, ta: 32'h0};
        trap = 1'b0; ret = 1'b0; cause = '0; rpc = '0;
        if (q.size() == 0 && !m_blank) begin
            if (inst == ECALL || inst == EBREAK) begin
                trap = 1'b1; cause = (inst == ECALL) ? 32'd11 : 32'd3; rpc = pc;
            end else if (inst == MRET) begin
                ret = 1'b1;
            end else if (ASYNC && irq != 8'h00 && mstatus[3]) begin
                trap = 1'b1; cause = irq[0] ? 32'h8000_0007 : 32'h8000_000B; rpc = jf ? ja : pc;
            end
        end
        if (q.size() > 0) e = q.pop_front();
        else e.hold = trap | ret;
        chk("hold", 32'(o.hold), 32'(e.hold));
        chk("wr_en", 32'(o.en), 32'(e.en));
        chk("wr_addr", o.addr, e.addr);
        chk("wr_data", o.data, e.data);
        chk("int_assert", 32'(o.as), 32'(e.as));
        chk("int_addr", o.ta, e.ta);
        pend = e.en;
        pend_w = e;
        m_blank = e.as;
        if (trap) begin
            ms = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
            q.push_back('{1'b1, 1'b1, A_MEPC, rpc, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b1, A_MSTATUS, ms, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b1, A_MCAUSE, cause, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, mtvec});
        end
        if (ret) begin
            ms = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
            q.push_back('{1'b1, 1'b1, A_MSTATUS, ms, 1'b0, 32'h0});
            q.push_back('{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, mepc});
        end
        if (o.en === 1'b1 && o.addr == A_MCAUSE) dut_mcause = o.data;
        @(posedge clk);
        #1;
        if (pend) begin
            if (pend_w.addr == A_MEPC) mepc = pend_w.data;
            else if (pend_w.addr == A_MSTATUS) mstatus = pend_w.data;
        end
    endtask

    task automatic run(input int n);
        obs_t o;
        for (int k = 0; k < n; k++) cycle(o);
    endtask

    task automatic idle_wait();
        obs_t o;
        inst = NOP; irq = 8'h00; jf = 1'b0;
        for (int k = 0; k < 20 && (q.size() != 0 || m_blank); k++) cycle(o);
        if (q.size() != 0 || m_blank) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: got busy, expected idle within 20 cycles");
        end
    endtask

    initial begin
        obs_t        o;
        logic        h, en, as;
        logic [31:0] ea, ed;
        int          n;

        vt[0] = '{ECALL, 32'h100, 1'b0, 32'h0, 8'h00, 32'h8, 32'h400, 32'h0, 1, 32'h100, 32'h80, 32'd11, 32'h400};
        vt[1] = '{MRET, 32'h10, 1'b0, 32'h0, 8'h00, 32'h80, 32'h400, 32'h104, 2, 32'h0, 32'h88, 32'h0, 32'h104};
        vt[2] = '{NOP, 32'h1F0, 1'b1, 32'h200, 8'h01, 32'h8, 32'h400, 32'h0, ASYNC ? 1 : 0,
                  32'h200, 32'h80, 32'h8000_0007, 32'h400};
        vt[3] = '{NOP, 32'h1F0, 1'b1, 32'h200, 8'h01, 32'h0, 32'h400, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        vt[4] = '{EBREAK, 32'h300, 1'b0, 32'h0, 8'h00, 32'h88, 32'h800, 32'h0, 1, 32'h300, 32'h80, 32'd3, 32'h800};
        vt[5] = '{NOP, 32'h240, 1'b0, 32'h999, 8'h02, 32'h1808, 32'h900, 32'h0, ASYNC ? 1 : 0,
                  32'h240, 32'h1880, 32'h8000_000B, 32'h900};
        vt[6] = '{ECALL, 32'h44, 1'b0, 32'h0, 8'hFF, 32'h8, 32'h400, 32'h0, 1, 32'h44, 32'h80, 32'd11, 32'h400};
        vt[7] = '{MRET, 32'h10, 1'b0, 32'h0, 8'h00, 32'h8, 32'h400, 32'h55, 2, 32'h0, 32'h80, 32'h0, 32'h55};
        vt[8] = '{ECALL, 32'h1000, 1'b0, 32'h0, 8'h00, 32'hFFFF_FF77, 32'hA00, 32'h0, 1,
                  32'h1000, 32'hFFFF_FF77, 32'd11, 32'hA00};
        vt[9] = '{NOP, 32'h20, 1'b0, 32'h0, 8'hFF, 32'h8, 32'hB00, 32'h0, ASYNC ? 1 : 0,
                  32'h20, 32'h80, 32'h8000_0007, 32'hB00};

        rst = 1'b1; inst = NOP; pc = '0; jf = 1'b0; ja = '0; irq = 8'h00;
        mtvec = '0; mepc = '0; mstatus = '0; dut_mcause = '0;
        #2;
        chk("rst_hold", 32'(hold), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_int_assert", 32'(int_assert), 32'h0);
        chk("rst_int_addr", int_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vector table, checked against hand-derived per-cycle values.
        for (int i = 0; i < 10; i++) begin
            idle_wait();
            mstatus = vt[i].ms; mtvec = vt[i].tvec; mepc = vt[i].epc;
            inst = vt[i].inst; pc = vt[i].pc; jf = vt[i].jf; ja = vt[i].ja; irq = vt[i].irq;
            n = (vt[i].kind == 2) ? 4 : 6;
            for (int c = 0; c < n; c++) begin
                cycle(o);
                h  = (vt[i].kind == 1 && c <= 4) || (vt[i].kind == 2 && c <= 2);
                en = (vt[i].kind == 1 && c >= 1 && c <= 3) || (vt[i].kind == 2 && c == 1);
                as = (vt[i].kind == 1 && c == 4) || (vt[i].kind == 2 && c == 2);
                ea = '0; ed = '0;
                if (vt[i].kind == 2 && c == 1) begin ea = A_MSTATUS; ed = vt[i].e_ms; end
                if (vt[i].kind == 1 && c == 1) begin ea = A_MEPC; ed = vt[i].e_mepc; end
                if (vt[i].kind == 1 && c == 2) begin ea = A_MSTATUS; ed = vt[i].e_ms; end
                if (vt[i].kind == 1 && c == 3) begin ea = A_MCAUSE; ed = vt[i].e_cause; end
                chk("tbl_hold", 32'(o.hold), 32'(h));
                chk("tbl_wr_en", 32'(o.en), 32'(en));
                chk("tbl_wr_addr", o.addr, ea);
                chk("tbl_wr_data", o.data, ed);
                chk("tbl_int_assert", 32'(o.as), 32'(as));
                chk("tbl_int_addr", o.ta, as ? vt[i].e_tgt : 32'h0);
            end
        end

        // Reset pulsed during W_MSTATUS aborts the sequence before mcause is written.
        idle_wait();
        mstatus = 32'h8; mtvec = 32'h400; mepc = 32'h0;
        inst = ECALL; pc = 32'h500; dut_mcause = 32'hDEAD;
        run(2);
        rst = 1'b1; inst = NOP;
        #1;
        chk("midrst_hold", 32'(hold), 32'h0);
        chk("midrst_wr_en", 32'(wr_en), 32'h0);
        chk("midrst_wr_addr", wr_addr, 32'h0);
        chk("midrst_wr_data", wr_data, 32'h0);
        chk("midrst_int_assert", 32'(int_assert), 32'h0);
        q.delete(); m_blank = 1'b0; pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(2);
        chk("midrst_no_mcause", dut_mcause, 32'hDEAD);
        inst = ECALL; pc = 32'h600;
        run(6);
        chk("midrst_new_mcause", dut_mcause, 32'd11);

        // ebreak wins over a pending interrupt; the interrupt follows once mret restores MIE.
        idle_wait();
        mstatus = 32'h8; mtvec = 32'h700; inst = EBREAK; pc = 32'h800; irq = 8'h02; dut_mcause = '0;
        run(6);
        chk("prio_first_cause", dut_mcause, 32'd3);
        inst = NOP;
        run(2);
        inst = MRET;
        run(4);
        inst = NOP;
        run(6);
        chk("prio_second_cause", dut_mcause, ASYNC ? 32'h8000_000B : 32'd3);

        // Randomized traffic against the model.
        idle_wait();
        for (int k = 0; k < 600; k++) begin
            if (q.size() == 0) begin
                case ($urandom_range(0, 5))
                    0: inst = ECALL;
                    1: inst = EBREAK;
                    2: inst = MRET;
                    default: inst = $urandom;
                endcase
                pc = $urandom & 32'hFFFF_FFFC;
                ja = $urandom & 32'hFFFF_FFFC;
                jf = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    mstatus = $urandom; mtvec = $urandom; mepc = $urandom;
                end
            end
            irq = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            cycle(o);
        end
        idle_wait();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
